// File: rtl/collatz_pkg.sv
// Shared types and constants for the Collatz engine: FSM states, default widths
// and the byte-select codes used by the optional output mux (COLLATZ_OUTMUX_EN).
package collatz_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int STEP_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SEL_STEPS   = 2'd0;
    localparam logic [1:0] SEL_PEAK_LO = 2'd1;
    localparam logic [1:0] SEL_PEAK_HI = 2'd2;
    localparam logic [1:0] SEL_STATUS  = 2'd3;

endpackage

// File: rtl/collatz_step.sv
// Combinational single Collatz step: halves even values, forms 3n+1 for odd values
// two bits wider than the datapath so overflow is detected rather than wrapped.
module collatz_step
    import collatz_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] n,
    output logic [ACC_W-1:0] next_n,
    output logic             is_one,
    output logic             ovf
);

    logic [ACC_W+1:0] n_wide;
    logic [ACC_W+1:0] triple;

    always_comb begin
        n_wide = {2'b00, n};
        triple = (n_wide << 1) + n_wide + (ACC_W+2)'(1);
        // Only the odd branch can overflow; halving always fits.
        ovf    = n[0] && (triple[ACC_W+1:ACC_W] != 2'b00);
        next_n = n[0] ? triple[ACC_W-1:0] : (n >> 1);
        is_one = (n == ACC_W'(1));
    end

endmodule

// File: rtl/collatz_core.sv
// Iterative Collatz engine: loads a seed on start, steps once per enabled clock until 1,
// and reports step count, peak value and error flags. COLLATZ_OUTMUX_EN adds a registered byte mux.
module collatz_core
    import collatz_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps,
    output logic [ACC_W-1:0]  peak,
    output logic              ovf,
    output logic              sat,
    output logic              zero_err,
`ifdef COLLATZ_OUTMUX_EN
    input  logic [1:0]        out_sel,
    output logic [7:0]        out_byte,
`endif
    output state_t            fsm_state
);

    // Handshake: start is a level request with no ready; it is taken on any enabled
    // edge while in IDLE or DONE (seed sampled on that edge) and ignored in RUN.

    state_t            state;
    state_t            state_next;
    logic [ACC_W-1:0]  n;
    logic [ACC_W-1:0]  n_next;
    logic [STEP_W-1:0] steps_next;
    logic [ACC_W-1:0]  peak_next;
    logic              ovf_next;
    logic              sat_next;
    logic              zero_next;

    logic [ACC_W-1:0]  step_n;
    logic              step_is_one;
    logic              step_ovf;
    logic [ACC_W-1:0]  seed_ext;

    assign seed_ext  = ACC_W'(seed);
    assign fsm_state = state;

    collatz_step #(
        .ACC_W (ACC_W)
    ) u_step (
        .n      (n),
        .next_n (step_n),
        .is_one (step_is_one),
        .ovf    (step_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        n_next     = n;
        steps_next = steps;
        peak_next  = peak;
        ovf_next   = ovf;
        sat_next   = sat;
        zero_next  = zero_err;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    n_next     = seed_ext;
                    steps_next = '0;
                    peak_next  = seed_ext;
                    ovf_next   = 1'b0;
                    sat_next   = 1'b0;
                    zero_next  = 1'b0;
                    if (seed == '0) begin
                        state_next = DONE;
                        zero_next  = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                // Terminating conditions leave n/steps/peak at their last valid values.
                if (step_is_one) begin
                    state_next = DONE;
                end else if (&steps) begin
                    state_next = DONE;
                    sat_next   = 1'b1;
                end else if (step_ovf) begin
                    state_next = DONE;
                    ovf_next   = 1'b1;
                end else begin
                    n_next     = step_n;
                    steps_next = steps + STEP_W'(1);
                    peak_next  = (step_n > peak) ? step_n : peak;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n        <= '0;
            steps    <= '0;
            peak     <= '0;
            ovf      <= 1'b0;
            sat      <= 1'b0;
            zero_err <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (ena) begin
            n        <= n_next;
            steps    <= steps_next;
            peak     <= peak_next;
            ovf      <= ovf_next;
            sat      <= sat_next;
            zero_err <= zero_next;
            busy     <= (state_next == RUN);
            done     <= (state_next == DONE);
        end
    end

`ifdef COLLATZ_OUTMUX_EN
    logic [7:0] byte_next;

    // Narrow parameterisations zero-pad: the casts extend or truncate as needed.
    always_comb begin
        byte_next = 8'h00;
        case (out_sel)
            SEL_STEPS:   byte_next = 8'(steps);
            SEL_PEAK_LO: byte_next = 8'(peak);
            SEL_PEAK_HI: byte_next = 8'(peak >> 8);
            SEL_STATUS:  byte_next = {done, busy, ovf, sat, zero_err, 3'b000};
            default:     byte_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_byte <= 8'h00;
        end else if (ena) begin
            out_byte <= byte_next;
        end
    end
`endif

endmodule

// File: tb/tb_collatz_core.sv
// Directed bench for collatz_core: default, ACC_W=8 and STEP_W=4 instances,
// checking latency, results, clock-enable freeze, async reset and the optional byte mux.
module tb_collatz_core;
    import collatz_pkg::*;

    logic clk;
    logic rst_n;
    logic ena;

    logic        start, start_a, start_s;
    logic [7:0]  seed, seed_a, seed_s;

    logic        busy, done, ovf, sat, zero_err;
    logic [7:0]  steps;
    logic [15:0] peak;
    state_t      fsm_state;

    logic        busy_a, done_a, ovf_a, sat_a, zero_err_a;
    logic [7:0]  steps_a;
    logic [7:0]  peak_a;
    state_t      fsm_state_a;

    logic        busy_s, done_s, ovf_s, sat_s, zero_err_s;
    logic [3:0]  steps_s;
    logic [15:0] peak_s;
    state_t      fsm_state_s;

`ifdef COLLATZ_OUTMUX_EN
    logic [1:0]  out_sel, out_sel_a, out_sel_s;
    logic [7:0]  out_byte, out_byte_a, out_byte_s;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    // ---------------- DUTs ----------------
    collatz_core u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .seed      (seed),
        .busy      (busy),
        .done      (done),
        .steps     (steps),
        .peak      (peak),
        .ovf       (ovf),
        .sat       (sat),
        .zero_err  (zero_err),
`ifdef COLLATZ_OUTMUX_EN
        .out_sel   (out_sel),
        .out_byte  (out_byte),
`endif
        .fsm_state (fsm_state)
    );

    collatz_core #(.ACC_W(8)) u_dut_acc8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start_a),
        .seed      (seed_a),
        .busy      (busy_a),
        .done      (done_a),
        .steps     (steps_a),
        .peak      (peak_a),
        .ovf       (ovf_a),
        .sat       (sat_a),
        .zero_err  (zero_err_a),
`ifdef COLLATZ_OUTMUX_EN
        .out_sel   (out_sel_a),
        .out_byte  (out_byte_a),
`endif
        .fsm_state (fsm_state_a)
    );

    collatz_core #(.STEP_W(4)) u_dut_step4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start_s),
        .seed      (seed_s),
        .busy      (busy_s),
        .done      (done_s),
        .steps     (steps_s),
        .peak      (peak_s),
        .ovf       (ovf_s),
        .sat       (sat_s),
        .zero_err  (zero_err_s),
`ifdef COLLATZ_OUTMUX_EN
        .out_sel   (out_sel_s),
        .out_byte  (out_byte_s),
`endif
        .fsm_state (fsm_state_s)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic done_of(input int which);
        case (which)
            0:       return done;
            1:       return done_a;
            default: return done_s;
        endcase
    endfunction

    function automatic logic [31:0] steps_of(input int which);
        case (which)
            0:       return 32'(steps);
            1:       return 32'(steps_a);
            default: return 32'(steps_s);
        endcase
    endfunction

    function automatic logic [31:0] peak_of(input int which);
        case (which)
            0:       return 32'(peak);
            1:       return 32'(peak_a);
            default: return 32'(peak_s);
        endcase
    endfunction

    function automatic logic [31:0] flags_of(input int which);
        case (which)
            0:       return {29'b0, ovf, sat, zero_err};
            1:       return {29'b0, ovf_a, sat_a, zero_err_a};
            default: return {29'b0, ovf_s, sat_s, zero_err_s};
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Drives start for exactly one edge (edge k); returns #1 after that edge.
    task automatic launch(input int which, input logic [7:0] s);
        @(negedge clk);
        case (which)
            0:       begin seed = s;   start = 1'b1;   end
            1:       begin seed_a = s; start_a = 1'b1; end
            default: begin seed_s = s; start_s = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        start   = 1'b0;
        start_a = 1'b0;
        start_s = 1'b0;
    endtask

    // Counts edges after edge k until done; expects done after edge k+lat.
    task automatic wait_done(input int which, input int lat, input string tag);
        int edges;
        edges = 0;
        while (!done_of(which) && edges < 600) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check_eq({tag, "_latency"}, edges, lat);
    endtask

    task automatic expect_run(input logic [31:0] e_steps, input logic [31:0] e_peak,
                              input logic [31:0] e_flags);
        exp_q.push_back(e_steps);
        exp_q.push_back(e_peak);
        exp_q.push_back(e_flags);
    endtask

    task automatic check_result(input int which, input string tag);
        logic [31:0] e;
        if (exp_q.size() < 3) begin
            check_eq({tag, "_queue"}, 32'(exp_q.size()), 32'd3);
        end else begin
            e = exp_q.pop_front(); check_eq({tag, "_steps"}, steps_of(which), e);
            e = exp_q.pop_front(); check_eq({tag, "_peak"},  peak_of(which),  e);
            e = exp_q.pop_front(); check_eq({tag, "_flags"}, flags_of(which), e);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] mux_exp [4];
        int edges;

        rst_n = 1'b0;
        ena   = 1'b1;
        start = 1'b0; start_a = 1'b0; start_s = 1'b0;
        seed  = 8'd0; seed_a  = 8'd0; seed_s  = 8'd0;
`ifdef COLLATZ_OUTMUX_EN
        out_sel = SEL_STEPS; out_sel_a = SEL_STEPS; out_sel_s = SEL_STEPS;
`endif
        #2;
        check_eq("rst_busy",  busy, 0);
        check_eq("rst_done",  done, 0);
        check_eq("rst_steps", steps, 0);
        check_eq("rst_peak",  peak, 0);
        check_eq("rst_flags", {ovf, sat, zero_err}, 0);
        check_eq("rst_state", 32'(fsm_state), 32'(IDLE));
`ifdef COLLATZ_OUTMUX_EN
        check_eq("rst_out_byte", out_byte, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // seed 27: 111 steps, peak 9232
        expect_run(111, 9232, 0);
        launch(0, 8'd27);
        check_eq("s27_busy_k", busy, 1);
        check_eq("s27_state_k", 32'(fsm_state), 32'(RUN));
        wait_done(0, 112, "s27");
        check_result(0, "s27");
        check_eq("s27_busy_done", busy, 0);

`ifdef COLLATZ_OUTMUX_EN
        mux_exp[0] = 8'h6F; mux_exp[1] = 8'h10; mux_exp[2] = 8'h24; mux_exp[3] = 8'h80;
        check_eq("mux_sel0", out_byte, mux_exp[0]);
        for (int i = 1; i < 4; i++) begin
            out_sel = 2'(i);
            @(negedge clk);
            check_eq("mux_hold", out_byte, mux_exp[i-1]);
            @(posedge clk);
            #1;
            check_eq("mux_sel", out_byte, mux_exp[i]);
        end
        out_sel = SEL_STEPS;
`else
        mux_exp[0] = 8'h6F;
        check_eq("s27_steps_hex", steps, mux_exp[0]);
`endif
        repeat (3) @(posedge clk);
        #1;
        check_eq("done_hold", done, 1);
        check_eq("done_hold_steps", steps, 111);

        // seed 1: a new start clears done on the loading edge
        expect_run(0, 1, 0);
        launch(0, 8'd1);
        check_eq("s1_done_clr", done, 0);
        check_eq("s1_busy_k", busy, 1);
        check_eq("s1_steps_k", steps, 0);
        wait_done(0, 1, "s1");
        check_result(0, "s1");

        // seed 0: straight to DONE with zero_err
        launch(0, 8'd0);
        check_eq("s0_done", done, 1);
        check_eq("s0_busy", busy, 0);
        check_eq("s0_steps", steps, 0);
        check_eq("s0_peak", peak, 0);
        check_eq("s0_flags", {ovf, sat, zero_err}, 3'b001);

        // seed 7 with a 5-cycle enable gap and an ignored start during RUN
        expect_run(16, 52, 0);
        launch(0, 8'd7);
        edges = 0;
        while (!done && edges < 600) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 3) ena = 1'b0;
            if (edges == 5) begin
                check_eq("freeze_busy", busy, 1);
                check_eq("freeze_steps", steps, 3);
                check_eq("freeze_peak", peak, 34);
            end
            if (edges == 8) ena = 1'b1;
            if (edges == 10) begin
                seed  = 8'd27;
                start = 1'b1;
            end
            if (edges == 11) start = 1'b0;
        end
        check_eq("s7_ena_latency", edges, 22);
        check_result(0, "s7_ena");

        // async reset mid-RUN clears outputs without a clock edge
        launch(0, 8'd7);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_steps", steps, 0);
        check_eq("mid_rst_peak", peak, 0);
        check_eq("mid_rst_flags", {ovf, sat, zero_err}, 0);
        check_eq("mid_rst_state", 32'(fsm_state), 32'(IDLE));
`ifdef COLLATZ_OUTMUX_EN
        check_eq("mid_rst_out_byte", out_byte, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        expect_run(16, 52, 0);
        launch(0, 8'd7);
        wait_done(0, 17, "s7");
        check_result(0, "s7");

        // ACC_W=8: 3*107+1 overflows after 11 steps
        expect_run(11, 214, 3'b100);
        launch(1, 8'd27);
        wait_done(1, 12, "acc8");
        check_result(1, "acc8");
        check_eq("acc8_state", 32'(fsm_state_a), 32'(DONE));
        check_eq("acc8_busy", busy_a, 0);
`ifdef COLLATZ_OUTMUX_EN
        check_eq("acc8_out_byte", out_byte_a, 11);
`endif

        // STEP_W=4: counter saturates at 15 with n=2
        expect_run(15, 52, 3'b010);
        launch(2, 8'd7);
        wait_done(2, 16, "step4");
        check_result(2, "step4");
        check_eq("step4_state", 32'(fsm_state_s), 32'(DONE));
        check_eq("step4_busy", busy_s, 0);
`ifdef COLLATZ_OUTMUX_EN
        check_eq("step4_out_byte", out_byte_s, 15);
`endif

        check_eq("queue_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
